alu_ctrl_exec: RTL and testbench
================================

# alu_ctrl_exec

Execution slice of the 16-bit, 8-register processor core: a multi-cycle control FSM plus a registered 16-bit ALU. On `run` it captures one instruction, sequences operand-latch, execute and write-back strobes for the surrounding register file, and produces the ALU result. Register file and operand fetch stay in the enclosing core. This block supplies the decoded register indices, the strobes and the result.

## Interface
- No parameters. Data width is 16 bits and there are 8 registers, both fixed.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: start request, level-sampled in IDLE only.
- `instruction` in 16: instruction word.
- `in_a` in 16: value of register Rx from the core register file.
- `in_b` in 16: value of register Ry from the core register file.
- `en_s` out 1: operand-latch strobe.
- `en_c` out 1: execute/capture strobe.
- `en_reg` out 8: one-hot write-back enable for register Rx.
- `done` out 1: one-cycle completion pulse.
- `rx` out 3: destination/first-source index, IR[15:13].
- `ry` out 3: second-source index, IR[12:10].
- `alu_out` out 16: registered ALU result.
- `zero` out 1: high when `alu_out` == 0.

## Operation
- Instruction fields, taken from the captured instruction register IR:
  - Rx = [15:13]
  - Ry = [12:10]
  - sel = [4:2]
  - fmt = [1:0]
- Operand B:
  - fmt == 2'b01: immediate {8'h00, IR[12:5]}. `in_b` is ignored.
  - fmt 00, 10, 11: register operand `in_b`.
- Operand A is always `in_a`.
- ALU ops by sel. All arithmetic is modulo 2^16, carry and borrow are discarded.
  - 0: ADD, A+B
  - 1: SUB, A−B
  - 2: AND
  - 3: OR
  - 4: XOR
  - 5: SHL, A << B[3:0]
  - 6: SHR logical, A >> B[3:0], zero fill
  - 7: PASS, B
- The operand latch captures A and B (after the immediate mux) at the rising edge ending LOAD.
- `alu_out` loads f(latched A, latched B, sel) at the rising edge ending EXEC. It holds its value otherwise, including across later instructions, until the next EXEC.
- FSM states and transitions:
  - IDLE: if `run`=1, capture IR from `instruction` and go to LOAD. Otherwise stay.
  - LOAD (`en_s`=1) → EXEC.
  - EXEC (`en_c`=1) → WB.
  - WB (`en_reg` = 1 << Rx) → DONE.
  - DONE (`done`=1) → IDLE.
- Outputs are Moore-decoded from state. Exactly one of `en_s`, `en_c`, `en_reg`≠0, `done` is active in each non-IDLE state. All are 0 in IDLE.
- `rx` and `ry` reflect IR at all times.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = IDLE
  - IR = 0
  - operand latches = 0
  - `alu_out` = 0, so `zero` = 1
  - `en_s` = `en_c` = `done` = 0, `en_reg` = 0
- Latency from the edge sampling `run`=1:
  - `en_s` high in cycle 1
  - `en_c` high in cycle 2
  - `en_reg` high in cycle 3, with `alu_out` already valid
  - `done` high in cycle 4
  - back in IDLE in cycle 5
- Throughput: one instruction per 5 cycles.
- `run` is ignored outside IDLE. Holding `run`=1 continuously restarts immediately after DONE → IDLE, capturing the then-current `instruction`.
- Changes to `instruction` after capture have no effect. `in_a` and `in_b` must be stable at the edge ending LOAD.
- Reset mid-operation aborts the operation: no further strobes, and `alu_out` clears to 0.
- A shift amount of 0 returns A. Shift amounts up to 15 are fully defined.

## Test plan
- Reset → all strobes 0, `alu_out`=0x0000, `zero`=1. Pulse reset during EXEC → immediate IDLE, no `en_reg` or `done`.
- `instruction`=0x2800 (ADD R1,R2), `in_a`=5, `in_b`=7, one-cycle `run` → `en_s`, `en_c`, `en_reg`=0x02, `done` in cycles 1–4. `alu_out`=0x000C from cycle 3.
- `instruction`=0x7FE1 (ADD R3, imm 0xFF), `in_a`=0x0001, `in_b`=0x1234 → `alu_out`=0x0100, `en_reg`=0x08.
- `instruction`=0x0404 (SUB R0,R1), `in_a`=0, `in_b`=1 → `alu_out`=0xFFFF, `en_reg`=0x01, `zero`=0. Then `in_a`=`in_b`=0x00AA → `alu_out`=0, `zero`=1.
- `instruction`=0xE014 (SHL R7), `in_a`=0x0001, `in_b`=0x0013 → `alu_out`=0x0008 (shift 3), `en_reg`=0x80. With sel=6, `in_a`=0x8000, `in_b`=0x000F → 0x0001.
- `run` held high with `instruction` changed during LOAD → the first result uses the original IR, the second op starts in the cycle after DONE using the new word. Toggling `run` mid-sequence has no effect.

Source files
------------

// File: rtl/alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_exec
//  Description : Execution slice of the 16-bit, 8-register core. A five-state
//                control FSM captures one instruction on run, drives the
//                operand-latch, execute and write-back strobes for the
//                enclosing register file, and produces a registered 16-bit
//                ALU result with a zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instruction,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        en_s,
    output logic        en_c,
    output logic [7:0]  en_reg,
    output logic        done,
    output logic [2:0]  rx,
    output logic [2:0]  ry,
    output logic [15:0] alu_out,
    output logic        zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] c_FMT_IMM = 2'b01;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic [15:0] r_alu_out;
    logic [15:0] w_op_b_mux;
    logic [15:0] w_alu_result;
    logic [2:0]  w_sel;
    logic [1:0]  w_fmt;

    assign w_sel = r_ir[4:2];
    assign w_fmt = r_ir[1:0];
    assign rx    = r_ir[15:13];
    assign ry    = r_ir[12:10];

    // Immediate format replaces the register operand with the zero-extended
    // 8-bit field that overlaps Ry and the spare bits.
    assign w_op_b_mux = (w_fmt == c_FMT_IMM) ? {8'h00, r_ir[12:5]} : in_b;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing and Moore strobe decode
    always_comb begin
        w_next_state = r_state;
        en_s         = 1'b0;
        en_c         = 1'b0;
        en_reg       = 8'h00;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                en_s         = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                en_c         = 1'b1;
                w_next_state = S_WB;
            end
            S_WB: begin
                en_reg       = 8'b0000_0001 << r_ir[15:13];
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Instruction register: captured only when a new operation is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir <= 16'h0000;
        end else if (r_state == S_IDLE && run) begin
            r_ir <= instruction;
        end
    end

    // Operand latches: sample A and muxed B at the end of LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a <= 16'h0000;
            r_op_b <= 16'h0000;
        end else if (r_state == S_LOAD) begin
            r_op_a <= in_a;
            r_op_b <= w_op_b_mux;
        end
    end

    // ALU function on the latched operands; carries and borrows are dropped
    always_comb begin
        w_alu_result = 16'h0000;
        case (w_sel)
            3'd0:    w_alu_result = r_op_a + r_op_b;
            3'd1:    w_alu_result = r_op_a - r_op_b;
            3'd2:    w_alu_result = r_op_a & r_op_b;
            3'd3:    w_alu_result = r_op_a | r_op_b;
            3'd4:    w_alu_result = r_op_a ^ r_op_b;
            3'd5:    w_alu_result = r_op_a << r_op_b[3:0];
            3'd6:    w_alu_result = r_op_a >> r_op_b[3:0];
            default: w_alu_result = r_op_b;
        endcase
    end

    // Result register: updates only at the end of EXEC and holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_out <= 16'h0000;
        end else if (r_state == S_EXEC) begin
            r_alu_out <= w_alu_result;
        end
    end

    assign alu_out = r_alu_out;
    assign zero    = (r_alu_out == 16'h0000);

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_exec
//  Description : Self-checking bench for alu_ctrl_exec: directed vector table,
//                multi-cycle corner sequences and random ops against a
//                behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_exec;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] instruction;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        en_s;
    logic        en_c;
    logic [7:0]  en_reg;
    logic        done;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] alu_out;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_ctrl_exec dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .in_a        (in_a),
        .in_b        (in_b),
        .en_s        (en_s),
        .en_c        (en_c),
        .en_reg      (en_reg),
        .done        (done),
        .rx          (rx),
        .ry          (ry),
        .alu_out     (alu_out),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_alu;
        logic [7:0]  exp_reg;
    } vec_t;

    vec_t vecs [7];

    // Reference model: computes the result from the instruction fields with
    // plain integer arithmetic.
    function automatic logic [15:0] ref_alu(input logic [15:0] ins,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned sh;
        int unsigned res;
        ua = a;
        ub = (ins[1:0] == 2'b01) ? int'(ins[12:5]) : int'(b);
        sh = ub % 16;
        case (ins[4:2])
            3'd0:    res = (ua + ub) % 65536;
            3'd1:    res = (ua + 65536 - ub) % 65536;
            3'd2:    res = ua & ub;
            3'd3:    res = ua | ub;
            3'd4:    res = ua ^ ub;
            3'd5:    res = (ua * (2 ** sh)) % 65536;
            3'd6:    res = ua / (2 ** sh);
            default: res = ub;
        endcase
        return res[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packed view: {en_s, en_c, en_reg[7:0], done}
    task automatic chk_strobes(input string name, input logic [10:0] exp);
        check(name, {21'd0, en_s, en_c, en_reg, done}, {21'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation with a one-cycle run pulse, checked cycle by cycle
    task automatic run_op(input string tag, input logic [15:0] ins,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_alu, input logic [7:0] exp_reg);
        instruction = ins;
        in_a        = a;
        in_b        = b;
        run         = 1'b1;
        tick;                                   // cycle 1: LOAD
        run         = 1'b0;
        instruction = ~ins;
        chk_strobes({tag, " c1"}, {1'b1, 1'b0, 8'h00, 1'b0});
        check({tag, " rx"}, {29'd0, rx}, {29'd0, ins[15:13]});
        check({tag, " ry"}, {29'd0, ry}, {29'd0, ins[12:10]});
        tick;                                   // cycle 2: EXEC
        in_a = ~a;
        in_b = ~b;
        chk_strobes({tag, " c2"}, {1'b0, 1'b1, 8'h00, 1'b0});
        tick;                                   // cycle 3: WB
        chk_strobes({tag, " c3"}, {1'b0, 1'b0, exp_reg, 1'b0});
        check({tag, " alu"}, {16'd0, alu_out}, {16'd0, exp_alu});
        check({tag, " zero"}, {31'd0, zero}, {31'd0, (exp_alu == 16'h0000)});
        tick;                                   // cycle 4: DONE
        chk_strobes({tag, " c4"}, {1'b0, 1'b0, 8'h00, 1'b1});
        tick;                                   // cycle 5: IDLE
        chk_strobes({tag, " c5"}, 11'd0);
        check({tag, " hold"}, {16'd0, alu_out}, {16'd0, exp_alu});
    endtask

    initial begin
        logic [15:0] ins_a;
        logic [15:0] ins_b;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] ri;

        vecs[0] = '{16'h2800, 16'h0005, 16'h0007, 16'h000C, 8'h02};
        vecs[1] = '{16'h7FE1, 16'h0001, 16'h1234, 16'h0100, 8'h08};
        vecs[2] = '{16'h0404, 16'h0000, 16'h0001, 16'hFFFF, 8'h01};
        vecs[3] = '{16'h0404, 16'h00AA, 16'h00AA, 16'h0000, 8'h01};
        vecs[4] = '{16'hE014, 16'h0001, 16'h0013, 16'h0008, 8'h80};
        vecs[5] = '{16'hE018, 16'h8000, 16'h000F, 16'h0001, 8'h80};
        vecs[6] = '{16'h4010, 16'h1234, 16'h0000, 16'h1234, 8'h04};

        reset       = 1'b1;
        run         = 1'b0;
        instruction = 16'h0000;
        in_a        = 16'h0000;
        in_b        = 16'h0000;
        #2;
        chk_strobes("reset strobes", 11'd0);
        check("reset alu", {16'd0, alu_out}, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd1);
        check("reset rx", {29'd0, rx}, 32'd0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk_strobes("idle strobes", 11'd0);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ins, vecs[i].a, vecs[i].b,
                   vecs[i].exp_alu, vecs[i].exp_reg);
        end

        // Reset during EXEC aborts the operation
        run_op("pre_rst", 16'h2800, 16'h0005, 16'h0007, 16'h000C, 8'h02);
        instruction = 16'h6000;
        in_a        = 16'h0003;
        in_b        = 16'h0004;
        run         = 1'b1;
        tick;
        run = 1'b0;
        tick;                                   // EXEC
        chk_strobes("rst exec", {1'b0, 1'b1, 8'h00, 1'b0});
        #2 reset = 1'b1;
        #1;
        chk_strobes("rst async strobes", 11'd0);
        check("rst async alu", {16'd0, alu_out}, 32'd0);
        check("rst async zero", {31'd0, zero}, 32'd1);
        tick;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk_strobes($sformatf("rst quiet c%0d", c), 11'd0);
        end

        // run held high, instruction changed during LOAD, run toggled mid-op
        ins_a       = 16'h2800;                 // ADD R1,R2
        ins_b       = 16'hA008;                 // AND R5,R0
        instruction = ins_a;
        in_a        = 16'h00F3;
        in_b        = 16'h0035;
        run         = 1'b1;
        tick;                                   // cycle 1
        instruction = ins_b;
        chk_strobes("hold c1", {1'b1, 1'b0, 8'h00, 1'b0});
        tick;                                   // cycle 2
        run = 1'b0;
        chk_strobes("hold c2", {1'b0, 1'b1, 8'h00, 1'b0});
        tick;                                   // cycle 3
        run = 1'b1;
        chk_strobes("hold c3", {1'b0, 1'b0, 8'h02, 1'b0});
        check("hold first alu", {16'd0, alu_out}, {16'd0, ref_alu(ins_a, 16'h00F3, 16'h0035)});
        tick;                                   // cycle 4
        chk_strobes("hold c4", {1'b0, 1'b0, 8'h00, 1'b1});
        tick;                                   // cycle 5: IDLE, samples run
        chk_strobes("hold c5", 11'd0);
        tick;                                   // cycle 6: LOAD of second op
        run = 1'b0;
        chk_strobes("hold c6", {1'b1, 1'b0, 8'h00, 1'b0});
        check("hold second rx", {29'd0, rx}, {29'd0, ins_b[15:13]});
        tick;
        tick;                                   // cycle 8: WB
        chk_strobes("hold c8", {1'b0, 1'b0, 8'h20, 1'b0});
        check("hold second alu", {16'd0, alu_out}, {16'd0, ref_alu(ins_b, 16'h00F3, 16'h0035)});
        tick;
        tick;

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            ri = 16'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op($sformatf("rnd%0d", n), ri, ra, rb, ref_alu(ri, ra, rb),
                   8'(1 << ri[15:13]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
